// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: data width, register-select width and the
// register-file clear/ready state encoding.
package riscv_pkg;
  localparam int XLEN           = 32;
  localparam int REG_SELECT_LEN = 5;

  typedef logic [REG_SELECT_LEN-1:0] reg_sel_t;
  typedef logic [XLEN-1:0]           word_t;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;
endpackage

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks x1..x(NREGS-1) issuing zero writes,
// then parks in RF_READY until the next reset.
module reg_file_clear_seq
  import riscv_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  output logic     clr_we,
  output reg_sel_t clr_idx,
  output logic     ready
);
  rf_state_t state, state_nxt;
  reg_sel_t  idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_idx <= reg_sel_t'(1);
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    clr_we    = 1'b0;
    if (state == RF_CLEAR) begin
      clr_we  = 1'b1;
      idx_nxt = clr_idx + 1'b1;
      if (clr_idx == reg_sel_t'(NREGS - 1)) state_nxt = RF_READY;
    end
  end

  // Derived from state so it drops asynchronously with rst_n.
  assign ready = (state == RF_READY);
endmodule

// File: rtl/reg_file.sv
// RV32 integer register file: 2 combinational read ports, 1 write port,
// x0 hardwired to zero. Optional REG_FILE_BYPASS_EN adds write-to-read bypass.
module reg_file
  import riscv_pkg::*;
#(
  parameter int NREGS = 32  // must equal 2**REG_SELECT_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_SELECT_LEN-1:0] rd_sel_1,
  output logic [XLEN-1:0]           rd_data_1,
  input  logic [REG_SELECT_LEN-1:0] rd_sel_2,
  output logic [XLEN-1:0]           rd_data_2,
  input  logic                      wr_en,
  input  logic [REG_SELECT_LEN-1:0] wr_sel,
  input  logic [XLEN-1:0]           wr_data,
  output logic                      ready,
  output logic                      wr_drop
);
  logic     clr_we;
  reg_sel_t clr_idx;
  logic     wr_acc;
  word_t    mem [NREGS];
  reg_sel_t rsel [2];
  word_t    rdat [2];

  reg_file_clear_seq #(.NREGS(NREGS)) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_we  (clr_we),
    .clr_idx (clr_idx),
    .ready   (ready)
  );

  assign wr_acc = ready && wr_en && (wr_sel != '0);

  // Unreset RAM-style storage; entry 0 is never written nor read.
  always_ff @(posedge clk) begin
    if (clr_we)      mem[clr_idx] <= '0;
    else if (wr_acc) mem[wr_sel]  <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_drop <= 1'b0;
    else        wr_drop <= wr_en && !ready;
  end

  assign rsel[0] = rd_sel_1;
  assign rsel[1] = rd_sel_2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    word_t arr;
    assign arr = (rsel[p] == '0) ? '0 : mem[rsel[p]];
`ifdef REG_FILE_BYPASS_EN
    assign rdat[p] = !ready ? '0 :
                     (wr_acc && (wr_sel == rsel[p])) ? wr_data : arr;
`else
    assign rdat[p] = ready ? arr : '0;
`endif
  end

  assign rd_data_1 = rdat[0];
  assign rd_data_2 = rdat[1];
endmodule

// File: tb/tb_reg_file.sv
// Randomized + directed bench for reg_file against an array-based reference.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rd_sel_1 = 5'd9, rd_sel_2 = 5'd9, wr_sel = '0;
  logic [31:0] rd_data_1, rd_data_2, wr_data = '0;
  logic        wr_en = 1'b0, ready, wr_drop;

  int n_tests = 0, n_fail = 0;

  logic [31:0] m_mem [32];
  logic        m_ready, m_drop;
  int          m_clr_left;

  reg_file dut (
    .clk(clk), .rst_n(rst_n),
    .rd_sel_1(rd_sel_1), .rd_data_1(rd_data_1),
    .rd_sel_2(rd_sel_2), .rd_data_2(rd_data_2),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .ready(ready), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] sel);
    if (!m_ready || sel == 0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && wr_sel != 0 && wr_sel == sel) return wr_data;
`endif
    return m_mem[sel];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_ready = 1'b0; m_drop = 1'b0; m_clr_left = 31;
  endtask

  task automatic check_reads(input string tag);
    chk({tag, "_rd1"}, rd_data_1, exp_rd(rd_sel_1));
    chk({tag, "_rd2"}, rd_data_2, exp_rd(rd_sel_2));
  endtask

  // One clock edge: update reference with the inputs seen at the edge,
  // then compare registered outputs.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) begin
      m_drop = wr_en && !m_ready;
      if (m_ready && wr_en && wr_sel != 0) m_mem[wr_sel] = wr_data;
      if (!m_ready) begin
        m_clr_left--;
        if (m_clr_left == 0) m_ready = 1'b1;
      end
    end
    #1;
    chk({tag, "_ready"}, {31'b0, ready}, {31'b0, m_ready});
    chk({tag, "_drop"}, {31'b0, wr_drop}, {31'b0, m_drop});
  endtask

  task automatic assert_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_drop", {31'b0, wr_drop}, 32'h0);
    check_reads("rst");
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    model_reset();

    // Reset release with selects parked on x9.
    rd_sel_1 = 5'd9; rd_sel_2 = 5'd9;
    assert_reset(3);
    for (int c = 1; c <= 31; c++) begin
      #1 check_reads("clr");
      chk("clr_ready_c", {31'b0, ready}, 32'h0);
      tick("clr");
    end
    chk("ready_at_32", {31'b0, ready}, 32'h1);
    check_reads("post_clr");

    // Basic write/read.
    wr_en = 1; wr_sel = 5; wr_data = 32'hDEADBEEF;
    tick("w5");
    wr_en = 0; rd_sel_1 = 5; rd_sel_2 = 5;
    #1 chk("x5_p1", rd_data_1, 32'hDEADBEEF);
    chk("x5_p2", rd_data_2, 32'hDEADBEEF);

    // x0 write is ignored without a drop.
    wr_en = 1; wr_sel = 0; wr_data = 32'h12345678;
    tick("w0");
    wr_en = 0; rd_sel_1 = 0; rd_sel_2 = 0;
    #1 chk("x0_p1", rd_data_1, 32'h0);
    chk("x0_p2", rd_data_2, 32'h0);
    chk("x0_drop", {31'b0, wr_drop}, 32'h0);

    // Same-cycle read/write of x7.
    wr_en = 1; wr_sel = 7; wr_data = 32'hA5A5A5A5; rd_sel_1 = 7; rd_sel_2 = 3;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("x7_same", rd_data_1, 32'hA5A5A5A5);
`else
    chk("x7_same", rd_data_1, 32'h0);
`endif
    chk("x7_other", rd_data_2, 32'h0);
    tick("w7");
    wr_en = 0;
    #1 chk("x7_next", rd_data_1, 32'hA5A5A5A5);

    // Randomized traffic in READY.
    for (int i = 0; i < 300; i++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_sel   = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rd_sel_1 = ($urandom_range(0, 3) == 0) ? wr_sel : 5'($urandom_range(0, 31));
      rd_sel_2 = ($urandom_range(0, 3) == 0) ? rd_sel_1 : 5'($urandom_range(0, 31));
      #1 check_reads("rand");
      tick("rand");
    end
    wr_en = 0;

    // Reset in READY with x12 holding data.
    wr_en = 1; wr_sel = 12; wr_data = 32'h55AA55AA;
    tick("w12");
    wr_en = 0; rd_sel_1 = 12; rd_sel_2 = 5;
    #1 chk("x12_pre", rd_data_1, 32'h55AA55AA);
    #2 assert_reset(1);

    // Write at clear cycle 10 gets dropped; reset again at cycle 15.
    for (int c = 1; c <= 15; c++) begin
      if (c == 10) begin wr_en = 1; wr_sel = 3; wr_data = 32'hFFFFFFFF; end
      #1 check_reads("clr2");
      tick("clr2");
      if (c == 10) chk("drop_c11", {31'b0, wr_drop}, 32'h1);
      wr_en = 0;
    end
    chk("drop_gone", {31'b0, wr_drop}, 32'h0);
    assert_reset(2);

    // Full 31-cycle clear required again; bounded wait for ready.
    cnt = 0;
    while (!ready && cnt < 40) begin
      #1 check_reads("clr3");
      tick("clr3");
      cnt++;
    end
    chk("clr3_len", cnt, 31);
    rd_sel_1 = 12; rd_sel_2 = 3;
    #1 chk("x12_zero", rd_data_1, 32'h0);
    chk("x3_zero", rd_data_2, 32'h0);
    rd_sel_1 = 5; rd_sel_2 = 7;
    #1 chk("x5_zero", rd_data_1, 32'h0);
    chk("x7_zero", rd_data_2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
